// File: rtl/test_pulse_gen_avmm_if.sv
// Avalon-MM slave bus bundle for the test pulse generator.
//   cs/addr/write/writedata/read : driven by the bus master
//   readdata                     : registered read data from the slave
// Clock and reset are kept outside the interface as plain ports.
interface test_pulse_gen_avmm_if;
  logic        cs;
  logic [2:0]  addr;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;

  modport master (
    output cs, addr, write, writedata, read,
    input  readdata
  );

  modport slave (
    input  cs, addr, write, writedata, read,
    output readdata
  );
endinterface

// File: rtl/test_pulse_gen_avmm.sv
// Test pulse generator: one start pulse and five stop pulses per frame,
// each with its own delay/width/enable word, fired by a trigger write.
// Ports:
//   avmm_clk    : clock, all logic on rising edge
//   avmm_reset  : asynchronous active-high reset
//   avmm        : Avalon-MM slave bus (read latency 1)
//   start_pulse : start channel output
//   stop_pulse  : stop channel outputs, bit n = stop n
// Register map: 0 CONTROL, 1 START, 2..6 STOP0..4, 7 FRAME_CNT.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | no frame running, trigger accepted
// ST_RUN  | frame running (busy), counter advancing, triggers ignored
module test_pulse_gen_avmm #(
  parameter logic OUT_POL = 1'b1
) (
  input  logic                  avmm_clk,
  input  logic                  avmm_reset,
  test_pulse_gen_avmm_if.slave  avmm,
  output logic                  start_pulse,
  output logic [4:0]            stop_pulse
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // index 0 = START, 1..5 = STOP0..STOP4
  logic [31:0] r_cfg  [6];
  logic [31:0] r_work [6];
  logic [16:0] r_cnt;
  logic [16:0] r_end;
  logic [5:0]  r_act;
  logic [31:0] r_readdata;

  logic        w_wr;
  logic        w_rd;
  logic        w_trig;
  logic        w_last;
  logic [16:0] w_cfg_end [6];
  logic [16:0] w_end_cfg;
  logic [16:0] w_lo [6];
  logic [16:0] w_hi [6];
  logic [5:0]  w_active;
  logic [31:0] w_rdata;

  assign w_wr   = avmm.cs & avmm.write;
  assign w_rd   = avmm.cs & avmm.read;
  assign w_trig = w_wr && (avmm.addr == 3'd0) && avmm.writedata[0] && (r_state == ST_IDLE);
  // Frame ends on the edge where the counter reaches END; END=0 still gives one busy cycle.
  assign w_last = (r_cnt + 17'd1) >= r_end;

  // Frame length from the live config, latched at trigger time.
  always_comb begin
    w_end_cfg = '0;
    for (int i = 0; i < 6; i++) begin
      w_cfg_end[i] = {1'b0, r_cfg[i][15:0]} + {2'b00, r_cfg[i][30:16]};
      if (r_cfg[i][31] && (r_cfg[i][30:16] != 15'd0) && (w_cfg_end[i] > w_end_cfg))
        w_end_cfg = w_cfg_end[i];
    end
  end

  // Window compare at 17 bits so DELAY+WIDTH never wraps.
  always_comb begin
    w_active = '0;
    for (int i = 0; i < 6; i++) begin
      w_lo[i] = {1'b0, r_work[i][15:0]};
      w_hi[i] = w_lo[i] + {2'b00, r_work[i][30:16]};
      if ((r_state == ST_RUN) && r_work[i][31] && (r_work[i][30:16] != 15'd0) &&
          (r_cnt >= w_lo[i]) && (r_cnt < w_hi[i]))
        w_active[i] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_trig) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge avmm_clk or posedge avmm_reset) begin
    if (avmm_reset) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_rdata = '0;
    case (avmm.addr)
      3'd0:    w_rdata = {30'd0, (r_state == ST_RUN), 1'b0};
      3'd1:    w_rdata = r_cfg[0];
      3'd2:    w_rdata = r_cfg[1];
      3'd3:    w_rdata = r_cfg[2];
      3'd4:    w_rdata = r_cfg[3];
      3'd5:    w_rdata = r_cfg[4];
      3'd6:    w_rdata = r_cfg[5];
      default: w_rdata = {15'd0, r_cnt};
    endcase
  end

  always_ff @(posedge avmm_clk or posedge avmm_reset) begin
    if (avmm_reset) begin
      for (int i = 0; i < 6; i++) begin
        r_cfg[i]  <= '0;
        r_work[i] <= '0;
      end
      r_cnt      <= '0;
      r_end      <= '0;
      r_act      <= '0;
      r_readdata <= '0;
    end else begin
      for (int i = 0; i < 6; i++)
        if (w_wr && (avmm.addr == 3'(i + 1))) r_cfg[i] <= avmm.writedata;

      if (w_trig) begin
        for (int i = 0; i < 6; i++) r_work[i] <= r_cfg[i];
        r_cnt <= '0;
        r_end <= w_end_cfg;
      end else if (r_state == ST_RUN) begin
        r_cnt <= r_cnt + 17'd1;
      end

      r_act <= w_active;

      // Sampled before this edge's write lands, so same-edge read returns the old value.
      if (w_rd) r_readdata <= w_rdata;
    end
  end

  assign avmm.readdata = r_readdata;
  assign start_pulse   = OUT_POL ? r_act[0]   : ~r_act[0];
  assign stop_pulse    = OUT_POL ? r_act[5:1] : ~r_act[5:1];

endmodule

// File: tb/tb_test_pulse_gen_avmm.sv
// Self-checking bench for test_pulse_gen_avmm: expected pulses (channel,
// first high cycle, width) are queued at trigger time from a local copy of
// the config and matched against pulses observed on the outputs.
module tb_test_pulse_gen_avmm;

  typedef struct {
    int ch;
    int rise;
    int width;
  } exp_t;

  logic       avmm_clk = 1'b0;
  logic       avmm_reset;
  logic       start_pulse;
  logic [4:0] stop_pulse;

  test_pulse_gen_avmm_if bus ();

  test_pulse_gen_avmm #(.OUT_POL(1'b1)) u_dut (
    .avmm_clk    (avmm_clk),
    .avmm_reset  (avmm_reset),
    .avmm        (bus),
    .start_pulse (start_pulse),
    .stop_pulse  (stop_pulse)
  );

  always #5 avmm_clk = ~avmm_clk;

  int cyc = 0;
  always @(posedge avmm_clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        sb_q[$];
  logic [31:0] cfg_m [6];
  bit          mon_en = 1'b0;
  logic [5:0]  prev_lvl = '0;
  logic [5:0]  lvl;
  int          rise_t [6];

  task automatic tb_check(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input int ch, input int rise, input int width);
    int idx;
    idx = -1;
    foreach (sb_q[k]) if (idx < 0 && sb_q[k].ch == ch) idx = k;
    tb_check($sformatf("pulse expected ch%0d", ch), (idx >= 0), 1);
    if (idx >= 0) begin
      tb_check($sformatf("rise ch%0d", ch), rise, sb_q[idx].rise);
      tb_check($sformatf("width ch%0d", ch), width, sb_q[idx].width);
      sb_q.delete(idx);
    end
  endtask

  // Pulse monitor, sampling mid-cycle.
  always @(negedge avmm_clk) begin
    lvl = {stop_pulse, start_pulse};
    if (mon_en) begin
      for (int i = 0; i < 6; i++) begin
        if (lvl[i] === 1'b1 && prev_lvl[i] !== 1'b1) rise_t[i] = cyc;
        else if (lvl[i] !== 1'b1 && prev_lvl[i] === 1'b1) sb_pop(i, rise_t[i], cyc - rise_t[i]);
      end
    end
    prev_lvl = lvl;
  end

  // All bus tasks start and end on a falling edge; the transfer is sampled
  // on the rising edge in between, whose number is cyc on return.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus.cs = 1'b1; bus.write = 1'b1; bus.addr = a; bus.writedata = d;
    @(negedge avmm_clk);
    bus.cs = 1'b0; bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus.cs = 1'b1; bus.read = 1'b1; bus.addr = a;
    @(negedge avmm_clk);
    d = bus.readdata;
    bus.cs = 1'b0; bus.read = 1'b0;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge avmm_clk);
  endtask

  task automatic prog(input int ch, input logic [31:0] v);
    bus_write(3'(ch + 1), v);
    cfg_m[ch] = v;
  endtask

  task automatic trigger(output int e0, output int endv);
    int d, w;
    bus_write(3'd0, 32'd1);
    e0 = cyc;
    endv = 0;
    for (int ch = 0; ch < 6; ch++) begin
      d = int'(cfg_m[ch][15:0]);
      w = int'(cfg_m[ch][30:16]);
      if (cfg_m[ch][31] && w != 0) begin
        sb_q.push_back('{ch: ch, rise: e0 + d + 1, width: w});
        if (d + w > endv) endv = d + w;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] d;
    int n;
    n = 0;
    d = 32'h2;
    while (d[1] && n < 1000) begin
      bus_read(3'd0, d);
      n++;
    end
    tb_check(tag, d[1], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int e0, endv;

    bus.cs = 1'b0; bus.write = 1'b0; bus.read = 1'b0; bus.addr = '0; bus.writedata = '0;
    for (int i = 0; i < 6; i++) cfg_m[i] = '0;
    avmm_reset = 1'b1;
    repeat (3) @(negedge avmm_clk);
    avmm_reset = 1'b0;

    tb_check("rst start_pulse", start_pulse, 0);
    tb_check("rst stop_pulse", stop_pulse, 0);
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), d);
      tb_check($sformatf("rst read a%0d", a), d, 0);
    end

    mon_en = 1'b1;

    // Frame 1: all channels enabled, 10-cycle pulses.
    prog(0, 32'h800A000A);
    prog(1, 32'h800A0014);
    prog(2, 32'h800A0032);
    prog(3, 32'h800A0064);
    prog(4, 32'h800A00C8);
    prog(5, 32'h800A01F4);
    trigger(e0, endv);
    wait_until(e0 + 49);
    bus_read(3'd5, d);
    tb_check("readback STOP3", d, 32'h800A00C8);
    wait_until(e0 + 199);
    bus_read(3'd7, d);
    tb_check("frame_cnt mid a", d, 199);
    bus_read(3'd7, d);
    tb_check("frame_cnt mid b", d, 200);
    wait_until(e0 + endv - 1);
    bus_read(3'd0, d);
    tb_check("busy before end", d, 32'h2);
    bus_read(3'd0, d);
    tb_check("busy after end", d, 32'h0);
    bus_read(3'd7, d);
    tb_check("frame_cnt end", d, endv);
    wait_until(e0 + endv + 3);
    tb_check("frame1 all pulses seen", sb_q.size(), 0);

    // Frame 2: STOP0 disabled, STOP1 zero width, retrigger and START rewrite mid-frame.
    prog(1, 32'h000A0014);
    prog(2, 32'h80000032);
    trigger(e0, endv);
    wait_until(e0 + 99);
    bus_write(3'd0, 32'd1);
    wait_until(e0 + 149);
    prog(0, 32'h80050005);
    wait_until(e0 + endv + 3);
    tb_check("frame2 all pulses seen", sb_q.size(), 0);
    wait_idle("frame2 idle");

    // Frame 3: new START value, then reset while STOP2 is high.
    trigger(e0, endv);
    wait_until(e0 + 105);
    tb_check("stop2 high before reset", stop_pulse[2], 1);
    tb_check("frame3 pending pulses", sb_q.size(), 3);
    mon_en = 1'b0;
    #2 avmm_reset = 1'b1;
    #1;
    tb_check("reset start_pulse", start_pulse, 0);
    tb_check("reset stop_pulse", stop_pulse, 0);
    sb_q.delete();
    for (int i = 0; i < 6; i++) cfg_m[i] = '0;
    repeat (2) @(negedge avmm_clk);
    avmm_reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), d);
      tb_check($sformatf("post-reset read a%0d", a), d, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
